// File: rtl/rgb_pkg.sv
// Shared types and default constants for the RGB pixel arbiter.
package rgb_pkg;

   localparam int unsigned COLOR_W   = 8;
   localparam int unsigned MAX_BURST = 16;
   localparam int unsigned CNT_W     = 8;

   typedef struct packed {
      logic [COLOR_W-1:0] r;
      logic [COLOR_W-1:0] g;
      logic [COLOR_W-1:0] b;
   } rgb_pixel_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } arb_state_t;

endpackage

// File: rtl/rgb_out_reg.sv
// Output pipeline register: holds one tagged RGB beat until downstream takes it.
module rgb_out_reg
   import rgb_pkg::*;
#(
   parameter int unsigned PIX_W = rgb_pkg::COLOR_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic [3*PIX_W-1:0] pixel,
   input  logic               last,
   input  logic               src,
   input  logic               out_ready,
   output logic               out_valid,
   output logic [PIX_W-1:0]   out_r,
   output logic [PIX_W-1:0]   out_g,
   output logic [PIX_W-1:0]   out_b,
   output logic               out_last,
   output logic               out_src
);

   // Load a new beat, or drop valid once the held beat is consumed; data otherwise holds.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_r     <= '0;
         out_g     <= '0;
         out_b     <= '0;
         out_last  <= 1'b0;
         out_src   <= 1'b0;
      end else if (load) begin
         out_valid <= 1'b1;
         {out_r, out_g, out_b} <= pixel;
         out_last  <= last;
         out_src   <= src;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/rgb_pixel_arbiter.sv
// Round-robin burst arbiter sharing one registered RGB output between two sources.
module rgb_pixel_arbiter
   import rgb_pkg::*;
#(
   parameter int unsigned PIX_W     = rgb_pkg::COLOR_W,
   parameter int unsigned BURST_MAX = rgb_pkg::MAX_BURST
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in0_valid,
   output logic             in0_ready,
   input  logic             in0_last,
   input  logic [PIX_W-1:0] in0_r,
   input  logic [PIX_W-1:0] in0_g,
   input  logic [PIX_W-1:0] in0_b,
   input  logic             in1_valid,
   output logic             in1_ready,
   input  logic             in1_last,
   input  logic [PIX_W-1:0] in1_r,
   input  logic [PIX_W-1:0] in1_g,
   input  logic [PIX_W-1:0] in1_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [PIX_W-1:0] out_r,
   output logic [PIX_W-1:0] out_g,
   output logic [PIX_W-1:0] out_b,
   output logic             out_last,
   output logic             out_src
);

   arb_state_t         state, state_nx;
   logic [CNT_W-1:0]   burst_cnt, burst_cnt_nx;
   logic               last_served, last_served_nx;
   logic               out_free;
   logic               acc0, acc1, acc;
   logic               sel_src, sel_last, rel;
   logic [3*PIX_W-1:0] sel_pix;

   // Handshake: only the granted source sees ready, and only when the output slot frees up.
   always_comb begin
      out_free  = !out_valid || out_ready;
      in0_ready = !reset && (state == GRANT0) && out_free;
      in1_ready = !reset && (state == GRANT1) && out_free;
      acc0      = in0_valid && in0_ready;
      acc1      = in1_valid && in1_ready;
      acc       = acc0 || acc1;
      sel_src   = acc1;
      sel_last  = acc1 ? in1_last : in0_last;
      sel_pix   = acc1 ? {in1_r, in1_g, in1_b} : {in0_r, in0_g, in0_b};
   end

   // Next grant, burst count and round-robin pointer; rotation happens with no idle bubble.
   always_comb begin
      state_nx       = state;
      burst_cnt_nx   = burst_cnt;
      last_served_nx = last_served;
      rel            = acc && (sel_last || (burst_cnt == CNT_W'(BURST_MAX - 1)));
      case (state)
         IDLE: begin
            if (in0_valid && in1_valid) state_nx = last_served ? GRANT0 : GRANT1;
            else if (in0_valid)         state_nx = GRANT0;
            else if (in1_valid)         state_nx = GRANT1;
         end
         GRANT0: begin
            if (rel) begin
               if (in1_valid)      state_nx = GRANT1;
               else if (in0_valid) state_nx = GRANT0;
               else                state_nx = IDLE;
            end
         end
         GRANT1: begin
            if (rel) begin
               if (in0_valid)      state_nx = GRANT0;
               else if (in1_valid) state_nx = GRANT1;
               else                state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
      if (rel) begin
         burst_cnt_nx   = '0;
         last_served_nx = sel_src;
      end else if (acc) begin
         burst_cnt_nx   = burst_cnt + CNT_W'(1);
      end
   end

   // Arbiter state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         burst_cnt   <= '0;
         last_served <= 1'b1;
      end else begin
         state       <= state_nx;
         burst_cnt   <= burst_cnt_nx;
         last_served <= last_served_nx;
      end
   end

   rgb_out_reg #(
      .PIX_W (PIX_W)
   ) u_out_reg (
      .clk       (clk),
      .reset     (reset),
      .load      (acc),
      .pixel     (sel_pix),
      .last      (sel_last),
      .src       (sel_src),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_r     (out_r),
      .out_g     (out_g),
      .out_b     (out_b),
      .out_last  (out_last),
      .out_src   (out_src)
   );

endmodule

// File: tb/tb_rgb_pixel_arbiter.sv
// Randomized self-checking bench for rgb_pixel_arbiter against a transaction-level model.
module tb_rgb_pixel_arbiter;
   import rgb_pkg::*;

   localparam int unsigned TB_MAX_BURST = 4;

   typedef struct packed {
      rgb_pixel_t pix;
      logic       last;
   } beat_t;

   typedef struct packed {
      rgb_pixel_t pix;
      logic       last;
      logic       src;
   } obs_t;

   logic               clk = 1'b0;
   logic               reset;
   logic               in0_valid, in0_ready, in0_last;
   logic               in1_valid, in1_ready, in1_last;
   logic [COLOR_W-1:0] in0_r, in0_g, in0_b, in1_r, in1_g, in1_b;
   logic               out_valid, out_ready, out_last, out_src;
   logic [COLOR_W-1:0] out_r, out_g, out_b;

   always #5 clk = ~clk;

   rgb_pixel_arbiter #(
      .PIX_W     (COLOR_W),
      .BURST_MAX (TB_MAX_BURST)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in0_valid (in0_valid),
      .in0_ready (in0_ready),
      .in0_last  (in0_last),
      .in0_r     (in0_r),
      .in0_g     (in0_g),
      .in0_b     (in0_b),
      .in1_valid (in1_valid),
      .in1_ready (in1_ready),
      .in1_last  (in1_last),
      .in1_r     (in1_r),
      .in1_g     (in1_g),
      .in1_b     (in1_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_r     (out_r),
      .out_g     (out_g),
      .out_b     (out_b),
      .out_last  (out_last),
      .out_src   (out_src)
   );

   beat_t       q0[$];
   beat_t       q1[$];
   obs_t        olog[$];
   beat_t       sent[$];
   int unsigned pv0, pv1, pr;
   int          n_tests = 0;
   int          n_fail  = 0;

   // Reference model: who owns the output, beats taken this grant, who went last, output slot.
   int          m_owner;
   int          m_cnt;
   int          m_last_srv;
   bit          m_ov, m_olast, m_osrc;
   rgb_pixel_t  m_opix;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic beat_t mk(input int unsigned r, input int unsigned g, input int unsigned b,
                                input bit last);
      beat_t x;
      x.pix.r = COLOR_W'(r);
      x.pix.g = COLOR_W'(g);
      x.pix.b = COLOR_W'(b);
      x.last  = last;
      return x;
   endfunction

   function automatic beat_t rnd_beat(input bit last);
      return mk($urandom_range(255), $urandom_range(255), $urandom_range(255), last);
   endfunction

   task automatic push_bursts(input int src, input int nb, input int blen, input bit with_last);
      for (int i = 0; i < nb; i++)
         for (int j = 0; j < blen; j++) begin
            if (src == 0) q0.push_back(rnd_beat(with_last && (j == blen - 1)));
            else          q1.push_back(rnd_beat(with_last && (j == blen - 1)));
         end
   endtask

   task automatic model_reset();
      m_owner    = -1;
      m_cnt      = 0;
      m_last_srv = 1;
      m_ov       = 1'b0;
      m_olast    = 1'b0;
      m_osrc     = 1'b0;
      m_opix     = '0;
   endtask

   task automatic drive(input bit rst);
      reset     = rst;
      in0_valid = (q0.size() > 0) && ($urandom_range(99) < pv0);
      in1_valid = (q1.size() > 0) && ($urandom_range(99) < pv1);
      if (q0.size() > 0) begin
         {in0_r, in0_g, in0_b} = q0[0].pix;
         in0_last              = q0[0].last;
      end else begin
         {in0_r, in0_g, in0_b} = 24'($urandom);
         in0_last              = 1'($urandom);
      end
      if (q1.size() > 0) begin
         {in1_r, in1_g, in1_b} = q1[0].pix;
         in1_last              = q1[0].last;
      end else begin
         {in1_r, in1_g, in1_b} = 24'($urandom);
         in1_last              = 1'($urandom);
      end
      out_ready = ($urandom_range(99) < pr);
   endtask

   // One clock: drive inputs, compare at the falling edge, advance the model, wait past posedge.
   task automatic cycle(input bit rst, input bit chk);
      bit         v[2];
      bit         l[2];
      bit         rd[2];
      rgb_pixel_t p[2];
      bit         free, taken;
      int         o;
      drive(rst);
      @(negedge clk);
      free  = !m_ov || out_ready;
      rd[0] = !rst && (m_owner == 0) && free;
      rd[1] = !rst && (m_owner == 1) && free;
      if (chk) begin
         check("out_valid", 32'(out_valid), 32'(m_ov));
         check("out_r",     32'(out_r),     32'(m_opix.r));
         check("out_g",     32'(out_g),     32'(m_opix.g));
         check("out_b",     32'(out_b),     32'(m_opix.b));
         check("out_last",  32'(out_last),  32'(m_olast));
         check("out_src",   32'(out_src),   32'(m_osrc));
         check("in0_ready", 32'(in0_ready), 32'(rd[0]));
         check("in1_ready", 32'(in1_ready), 32'(rd[1]));
      end
      if (out_valid === 1'b1 && out_ready === 1'b1)
         olog.push_back('{pix: '{r: out_r, g: out_g, b: out_b}, last: out_last, src: out_src});
      if (rst) begin
         model_reset();
      end else begin
         v[0] = in0_valid; v[1] = in1_valid;
         l[0] = in0_last;  l[1] = in1_last;
         p[0] = '{r: in0_r, g: in0_g, b: in0_b};
         p[1] = '{r: in1_r, g: in1_g, b: in1_b};
         taken = 1'b0;
         o     = m_owner;
         if (o < 0) begin
            if (v[0] && v[1]) m_owner = 1 - m_last_srv;
            else if (v[0])    m_owner = 0;
            else if (v[1])    m_owner = 1;
         end else if (v[o] && free) begin
            taken   = 1'b1;
            m_ov    = 1'b1;
            m_opix  = p[o];
            m_olast = l[o];
            m_osrc  = (o == 1);
            if (o == 0) void'(q0.pop_front());
            else        void'(q1.pop_front());
            m_cnt++;
            if (l[o] || m_cnt == int'(TB_MAX_BURST)) begin
               m_cnt      = 0;
               m_last_srv = o;
               if (v[1-o])    m_owner = 1 - o;
               else if (v[o]) m_owner = o;
               else           m_owner = -1;
            end
         end
         if (!taken && m_ov && out_ready) m_ov = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic start_phase();
      q0.delete();
      q1.delete();
      olog.delete();
      cycle(1'b1, 1'b1);
      cycle(1'b1, 1'b1);
   endtask

   initial begin
      int exp_src[$];
      reset = 1'b1; out_ready = 1'b0;
      in0_valid = 1'b0; in0_last = 1'b0; in0_r = '0; in0_g = '0; in0_b = '0;
      in1_valid = 1'b0; in1_last = 1'b0; in1_r = '0; in1_g = '0; in1_b = '0;
      pv0 = 100; pv1 = 100; pr = 100;
      model_reset();

      // Reset with both sources valid, then source 0 wins and its first pixel lands two cycles later.
      q0.push_back(mk(8'h10, 8'h20, 8'h30, 1'b0));
      q0.push_back(rnd_beat(1'b0));
      q0.push_back(rnd_beat(1'b1));
      push_bursts(1, 1, 3, 1'b1);
      cycle(1'b1, 1'b0);
      cycle(1'b1, 1'b1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_pix",   32'({out_r, out_g, out_b}), 32'd0);
      cycle(1'b0, 1'b1);
      cycle(1'b0, 1'b1);
      check("first_valid", 32'(out_valid), 32'd1);
      check("first_pix",   32'({out_r, out_g, out_b}), 32'h102030);
      check("first_src",   32'(out_src), 32'd0);
      for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1);

      // Back-to-back 3-beat bursts alternate with no idle cycles.
      start_phase();
      push_bursts(0, 3, 3, 1'b1);
      push_bursts(1, 3, 3, 1'b1);
      for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1);
      check("alt_count", 32'(olog.size()), 32'd18);
      for (int i = 0; i < olog.size(); i++) begin
         check("alt_src",  32'(olog[i].src),  32'((i / 3) % 2));
         check("alt_last", 32'(olog[i].last), 32'((i % 3) == 2));
      end

      // Forced rotation after TB_MAX_BURST beats; out_last stays the input's own last.
      start_phase();
      push_bursts(0, 1, 10, 1'b0);
      push_bursts(1, 2, 2, 1'b1);
      for (int i = 0; i < 25; i++) cycle(1'b0, 1'b1);
      exp_src = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0};
      check("rot_count", 32'(olog.size()), 32'(exp_src.size()));
      for (int i = 0; i < olog.size() && i < exp_src.size(); i++) begin
         check("rot_src",  32'(olog[i].src),  32'(exp_src[i]));
         check("rot_last", 32'(olog[i].last), 32'(exp_src[i] == 1 && (i % 6) == 5));
      end

      // Backpressure holds the AA/BB/CC beat and stalls the granted source.
      start_phase();
      pv1 = 0;
      q0.push_back(rnd_beat(1'b0));
      q0.push_back(rnd_beat(1'b0));
      q0.push_back(mk(8'hAA, 8'hBB, 8'hCC, 1'b0));
      q0.push_back(rnd_beat(1'b0));
      q0.push_back(rnd_beat(1'b0));
      q0.push_back(rnd_beat(1'b1));
      sent = q0;
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1);
      pr = 0;
      for (int i = 0; i < 5; i++) begin
         cycle(1'b0, 1'b1);
         check("bp_hold", 32'({out_r, out_g, out_b}), 32'hAABBCC);
         check("bp_valid", 32'(out_valid), 32'd1);
      end
      pr = 100;
      for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1);
      check("bp_count", 32'(olog.size()), 32'(sent.size()));
      for (int i = 0; i < olog.size() && i < sent.size(); i++)
         check("bp_order", 32'(olog[i].pix), 32'(sent[i].pix));

      // Lone requester with gaps keeps getting regranted.
      start_phase();
      pv0 = 0; pv1 = 50;
      push_bursts(1, 4, 2, 1'b1);
      for (int i = 0; i < 120; i++) cycle(1'b0, 1'b1);
      check("solo_count", 32'(olog.size()), 32'd8);
      for (int i = 0; i < olog.size(); i++)
         check("solo_src", 32'(olog[i].src), 32'd1);

      // Reset on the second beat of a source 1 burst drops the held beat; source 0 then wins.
      start_phase();
      pv0 = 0; pv1 = 100;
      push_bursts(1, 1, 4, 1'b1);
      cycle(1'b0, 1'b1);
      cycle(1'b0, 1'b1);
      check("mid_valid_pre", 32'(out_valid), 32'd1);
      cycle(1'b1, 1'b1);
      check("mid_valid_rst", 32'(out_valid), 32'd0);
      pv0 = 100;
      push_bursts(0, 1, 2, 1'b1);
      cycle(1'b0, 1'b1);
      cycle(1'b0, 1'b1);
      check("mid_src_after", 32'(out_src), 32'd0);
      check("mid_valid_after", 32'(out_valid), 32'd1);

      // Random traffic, backpressure and occasional resets.
      start_phase();
      for (int i = 0; i < 3000; i++) begin
         if (i % 50 == 0) begin
            pv0 = $urandom_range(100);
            pv1 = $urandom_range(100);
            pr  = $urandom_range(20, 100);
         end
         if (q0.size() < 4) push_bursts(0, 1, $urandom_range(1, 6), $urandom_range(3) != 0);
         if (q1.size() < 4) push_bursts(1, 1, $urandom_range(1, 6), $urandom_range(3) != 0);
         cycle($urandom_range(99) == 0, 1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
